// File: rtl/period_synth_pkg.sv
// Shared types and constants for the period synthesiser: sample/tau/step types,
// FSM state encodings and the shadow-register SILENCE encoding.
package period_synth_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_TAUMAX = 2048;
  localparam int DEF_TAUMIN = 20;
  localparam int DEF_TW     = $clog2(DEF_TAUMAX);

  typedef logic        [DEF_TW-1:0]    tau_t;
  typedef logic signed [DEF_WIDTH-1:0] sample_t;
  typedef logic        [DEF_WIDTH-1:0] step_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } main_state_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_DONE = 2'd2
  } div_state_e;

  // A shadow tau of zero marks a silence request (no waveform).
  localparam int SILENCE_TAU = 0;

endpackage

// File: rtl/period_synth_recip.sv
// recip_div: sequential restoring divider computing step = floor(2^WIDTH / tau),
// one quotient bit per clock over the WIDTH+1 bit dividend; a new start aborts a running divide.
module recip_div
  import period_synth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TW    = DEF_TW
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [TW-1:0]    tau,
  output logic [WIDTH-1:0] step,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);

  div_state_e       state_r;
  logic [WIDTH:0]   dvd_r;
  logic [WIDTH-1:0] quo_r;
  logic [TW-1:0]    div_r;
  logic [TW-1:0]    rem_r;
  logic [CW-1:0]    cnt_r;
  logic [TW:0]      trial_s;
  logic             fit_s;

  // Trial subtraction for the current quotient bit.
  always_comb begin
    trial_s = {rem_r, dvd_r[WIDTH]};
    fit_s   = (trial_s >= {1'b0, div_r});
  end

  // Divider sequencing and datapath; the top quotient bit is always 0 and shifts out.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= D_IDLE;
      dvd_r   <= '0;
      quo_r   <= '0;
      div_r   <= '0;
      rem_r   <= '0;
      cnt_r   <= '0;
    end else if (start) begin
      state_r <= D_BUSY;
      dvd_r   <= {1'b1, {WIDTH{1'b0}}};
      quo_r   <= '0;
      div_r   <= tau;
      rem_r   <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        D_BUSY: begin
          dvd_r <= {dvd_r[WIDTH-1:0], 1'b0};
          quo_r <= {quo_r[WIDTH-2:0], fit_s};
          rem_r <= fit_s ? TW'(trial_s - {1'b0, div_r}) : TW'(trial_s);
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH)) begin
            state_r <= D_DONE;
          end else begin
            state_r <= D_BUSY;
          end
        end
        D_DONE:  state_r <= D_IDLE;
        D_IDLE:  state_r <= D_IDLE;
        default: state_r <= D_IDLE;
      endcase
    end
  end

  assign step = quo_r;
  assign done = (state_r == D_DONE);
  assign busy = (state_r == D_BUSY);

endmodule

// File: rtl/period_synth.sv
// period_synth: turns a period tau into a periodic sawtooth (or triangle when
// PERIOD_SYNTH_TRI_EN is defined), switching period only at cycle boundaries.
module period_synth
  import period_synth_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int TAUMAX = DEF_TAUMAX,
  parameter int TAUMIN = DEF_TAUMIN
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [$clog2(TAUMAX)-1:0] tau_in,
  input  logic                      tau_valid_in,
  input  logic                      sample_tick_in,
  output logic [WIDTH-1:0]          sample_out,
  output logic                      valid_out,
  output logic                      busy_out
);

  localparam int TW = $clog2(TAUMAX);
  localparam logic [TW-1:0] SIL = TW'(SILENCE_TAU);
  localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] wave_f(input logic [WIDTH-1:0] acc);
    logic [WIDTH-1:0] tri_v;
`ifdef PERIOD_SYNTH_TRI_EN
    tri_v = acc[WIDTH-1] ? ((~acc) << 1) : (acc << 1);
`else
    tri_v = acc;
`endif
    return tri_v ^ SIGN_FLIP;
  endfunction

  logic [WIDTH-1:0] div_step_s;
  logic             div_done_s, div_busy_s;
  logic             tau_ok_s, start_s, quiet_s, fresh_s;
  logic             eff_pend_s, eff_live_s, at_wrap_s, consume_s;
  logic [TW-1:0]    eff_tau_s;
  logic [WIDTH-1:0] eff_step_s;

  logic [TW-1:0]    req_tau_r, sh_tau_r, act_tau_r, cnt_r;
  logic [WIDTH-1:0] sh_step_r, act_step_r, acc_r, sample_r;
  logic             drop_r, sh_pend_r, valid_r;
  main_state_e      state_r;

  recip_div #(.WIDTH(WIDTH), .TW(TW)) u_div (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .start  (start_s),
    .tau    (tau_in),
    .step   (div_step_s),
    .done   (div_done_s),
    .busy   (div_busy_s)
  );

  // Request decode and the effective shadow (a divide finishing this clock bypasses the register).
  always_comb begin
    tau_ok_s   = (tau_in >= TW'(TAUMIN));
    start_s    = tau_valid_in & tau_ok_s;
    quiet_s    = tau_valid_in & ~tau_ok_s;
    fresh_s    = div_done_s & ~drop_r;
    if (fresh_s) begin
      eff_tau_s  = req_tau_r;
      eff_step_s = div_step_s;
    end else begin
      eff_tau_s  = sh_tau_r;
      eff_step_s = sh_step_r;
    end
    eff_pend_s = fresh_s | sh_pend_r;
    eff_live_s = (eff_tau_s != SIL);
    at_wrap_s  = (state_r == RUN) && (cnt_r == act_tau_r - TW'(1));
    if (state_r == IDLE) begin
      consume_s = sample_tick_in & eff_pend_s & eff_live_s;
    end else begin
      consume_s = sample_tick_in & eff_pend_s & at_wrap_s;
    end
  end

  // Shadow bookkeeping; a silence request also discards any divide still in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req_tau_r <= '0;
      drop_r    <= 1'b0;
      sh_tau_r  <= SIL;
      sh_step_r <= '0;
      sh_pend_r <= 1'b0;
    end else begin
      if (start_s) begin
        req_tau_r <= tau_in;
        drop_r    <= 1'b0;
      end else if (quiet_s && div_busy_s) begin
        drop_r <= 1'b1;
      end else if (div_done_s) begin
        drop_r <= 1'b0;
      end
      if (quiet_s) begin
        sh_tau_r  <= SIL;
        sh_pend_r <= 1'b1;
      end else if (consume_s) begin
        sh_pend_r <= 1'b0;
      end else if (fresh_s) begin
        sh_tau_r  <= req_tau_r;
        sh_step_r <= div_step_s;
        sh_pend_r <= 1'b1;
      end
    end
  end

  // Main sample FSM; everything advances on sample ticks only.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= IDLE;
      act_tau_r  <= '0;
      act_step_r <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      sample_r   <= '0;
      valid_r    <= 1'b0;
    end else begin
      valid_r <= sample_tick_in;
      if (sample_tick_in) begin
        case (state_r)
          IDLE: begin
            sample_r <= '0;
            if (consume_s) begin
              state_r    <= RUN;
              act_tau_r  <= eff_tau_s;
              act_step_r <= eff_step_s;
              acc_r      <= '0;
              cnt_r      <= '0;
            end
          end
          RUN: begin
            sample_r <= wave_f(acc_r);
            if (at_wrap_s) begin
              acc_r <= '0;
              cnt_r <= '0;
              if (consume_s) begin
                if (eff_live_s) begin
                  act_tau_r  <= eff_tau_s;
                  act_step_r <= eff_step_s;
                end else begin
                  state_r <= IDLE;
                end
              end
            end else begin
              acc_r <= acc_r + act_step_r;
              cnt_r <= cnt_r + TW'(1);
            end
          end
          default: begin
            state_r  <= IDLE;
            sample_r <= '0;
          end
        endcase
      end
    end
  end

  assign sample_out = sample_r;
  assign valid_out  = valid_r;
  assign busy_out   = div_busy_s;

endmodule

// File: tb/tb_period_synth.sv
// Bench for period_synth: timestamp-based reference model compared every clock,
// plus directed scenarios with hand-computed values (PERIOD_SYNTH_TRI_EN selects triangle).
module tb_period_synth;

  localparam int TAUMIN = 20;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] tau_in = '0;
  logic        tau_valid_in = 1'b0;
  logic        sample_tick_in = 1'b0;
  logic [15:0] sample_out;
  logic        valid_out, busy_out;

  period_synth dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .tau_in        (tau_in),
    .tau_valid_in  (tau_valid_in),
    .sample_tick_in(sample_tick_in),
    .sample_out    (sample_out),
    .valid_out     (valid_out),
    .busy_out      (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int wave(input int acc);
`ifdef PERIOD_SYNTH_TRI_EN
    if (acc < 32768) return 2 * acc - 32768;
    else return 2 * (65535 - acc) - 32768;
`else
    return acc - 32768;
`endif
  endfunction

  // Reference model: waveform value = wave(pos*step mod 2^16); divides complete 18 clocks after request.
  int  cyc = 0;
  bit  m_run = 0, m_pend = 0, m_inflight = 0;
  int  m_sh_tau = 0, m_sh_step = 0, m_tau = 0, m_step = 0, m_pos = 0;
  int  m_if_tau = 0, m_done_at = 0, m_busy_until = -1;
  int  exp_sample = 0;
  bit  exp_valid = 0, exp_busy = 0;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_run = 0; m_pend = 0; m_inflight = 0; m_sh_tau = 0; m_sh_step = 0;
      m_tau = 0; m_step = 0; m_pos = 0; m_busy_until = -1;
      exp_sample = 0; exp_valid = 0; exp_busy = 0;
    end else begin
      cyc++;
      if (m_inflight && cyc == m_done_at) begin
        m_inflight = 0; m_pend = 1; m_sh_tau = m_if_tau; m_sh_step = 65536 / m_if_tau;
      end
      exp_valid = sample_tick_in;
      if (sample_tick_in) begin
        if (!m_run) begin
          exp_sample = 0;
          if (m_pend && m_sh_tau >= TAUMIN) begin
            m_run = 1; m_tau = m_sh_tau; m_step = m_sh_step; m_pos = 0; m_pend = 0;
          end
        end else begin
          exp_sample = wave((m_pos * m_step) % 65536);
          if (m_pos == m_tau - 1) begin
            m_pos = 0;
            if (m_pend) begin
              m_pend = 0;
              if (m_sh_tau < TAUMIN) m_run = 0;
              else begin m_tau = m_sh_tau; m_step = m_sh_step; end
            end
          end else m_pos++;
        end
      end
      if (tau_valid_in) begin
        if (int'(tau_in) >= TAUMIN) begin
          m_inflight = 1; m_if_tau = int'(tau_in); m_done_at = cyc + 18; m_busy_until = cyc + 16;
        end else begin
          m_inflight = 0; m_sh_tau = 0; m_pend = 1;
        end
      end
      exp_busy = (cyc <= m_busy_until);
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("valid_out", int'(valid_out), int'(exp_valid));
      chk("busy_out", int'(busy_out), int'(exp_busy));
      if (exp_valid) chk("sample_out", int'($signed(sample_out)), exp_sample);
    end
  end

  task automatic send_tau(input int v);
    tau_in = 11'(v);
    tau_valid_in = 1'b1;
    @(negedge clk_in);
    tau_valid_in = 1'b0;
  endtask

  task automatic tick_get(output int s);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    s = int'($signed(sample_out));
    @(negedge clk_in);
  endtask

  task automatic count_busy(input string name);
    int c = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy_out) c++;
      @(negedge clk_in);
    end
    chk(name, c, 17);
  endtask

`ifdef PERIOD_SYNTH_TRI_EN
  localparam int L_K1 = -31458, L_K2 = -30148, L_K99 = -31388, L_50_1 = -30148, L_200_1 = -32114;
`else
  localparam int L_K1 = -32113, L_K2 = -31458, L_K99 = 32077, L_50_1 = -31458, L_200_1 = -32441;
`endif

  initial begin
    int s;
    bit found, prev_wrap;
    int rate;
    #1 rst_in = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_busy", int'(busy_out), 0);

    // 1: tau=100, step 655
    send_tau(100);
    count_busy("t1_busy_clks");
    tick_get(s);
    chk("t1_idle_tick", s, 0);
    for (int k = 0; k <= 100; k++) begin
      tick_get(s);
      if (k == 0)   chk("t1_k0", s, -32768);
      if (k == 1)   chk("t1_k1", s, L_K1);
      if (k == 2)   chk("t1_k2", s, L_K2);
      if (k == 99)  chk("t1_k99", s, L_K99);
      if (k == 100) chk("t1_k100", s, -32768);
    end

    // 2: switch to tau=50 mid-cycle, applied at the wrap
    for (int p = 1; p < 30; p++) tick_get(s);
    send_tau(50);
    repeat (20) @(negedge clk_in);
    for (int p = 30; p <= 99; p++) begin
      tick_get(s);
      if (p == 99) chk("t2_old_p99", s, L_K99);
    end
    tick_get(s);
    chk("t2_wrap", s, -32768);
    tick_get(s);
    chk("t2_p1_step1310", s, L_50_1);
    for (int p = 2; p <= 49; p++) tick_get(s);
    tick_get(s);
    chk("t2_wrap50", s, -32768);

    // 3: abort tau=100 with tau=200 two clocks later
    send_tau(100);
    @(negedge clk_in);
    send_tau(200);
    count_busy("t3_busy_clks");
    found = 1'b0;
    prev_wrap = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick_get(s);
      if (prev_wrap && !found) begin
        chk("t3_step327", s, L_200_1);
        found = 1'b1;
      end
      prev_wrap = (s == -32768);
    end
    chk("t3_wrap_seen", int'(found), 1);

    // 4: silence at next boundary
    send_tau(5);
    for (int i = 0; i < 200; i++) tick_get(s);
    for (int i = 0; i < 5; i++) begin
      tick_get(s);
      chk("t4_silent", s, 0);
    end

    // 5: asynchronous reset between clock edges
    send_tau(100);
    repeat (20) @(negedge clk_in);
    for (int i = 0; i < 10; i++) tick_get(s);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    chk("t5_pre_valid", int'(valid_out), 1);
    #2 rst_in = 1'b1;
    #1;
    chk("t5_async_sample", int'(sample_out), 0);
    chk("t5_async_valid", int'(valid_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick_get(s);
      chk("t5_post_rst", s, 0);
    end

    // Randomised traffic with varying request density
    for (int blk = 0; blk < 6; blk++) begin
      rate = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 3 : 10);
      for (int c = 0; c < 3000; c++) begin
        tau_valid_in = ($urandom_range(0, 99) < rate);
        if ($urandom_range(0, 9) < 2) tau_in = 11'($urandom_range(0, 19));
        else if ($urandom_range(0, 19) == 0) tau_in = 11'($urandom_range(20, 2047));
        else tau_in = 11'($urandom_range(20, 150));
        sample_tick_in = ($urandom_range(0, 2) == 0);
        @(negedge clk_in);
      end
    end
    tau_valid_in = 1'b0;
    sample_tick_in = 1'b0;
    repeat (3) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
